// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the four requester ports and the RAM bus of the
// VRAM arbiter.
//   pN_addr/pN_wrdata/pN_wrbytesel/pN_write/pN_strobe : requester -> arbiter
//   pN_ack (combinational), pN_rddata_valid (registered) : arbiter -> requester
//   rddata                                              : shared read data
//   ram_addr/ram_wrdata/ram_wrbytesel/ram_write         : arbiter -> RAM
//   ram_rddata                                          : RAM -> arbiter
// slave modport is the arbiter; master modport is the requester/RAM side.
interface vram_arbiter_if;
  logic [14:0] p0_addr, p1_addr, p2_addr, p3_addr;
  logic [31:0] p0_wrdata, p1_wrdata, p2_wrdata, p3_wrdata;
  logic [3:0]  p0_wrbytesel, p1_wrbytesel, p2_wrbytesel, p3_wrbytesel;
  logic        p0_write, p1_write, p2_write, p3_write;
  logic        p0_strobe, p1_strobe, p2_strobe, p3_strobe;
  logic        p0_ack, p1_ack, p2_ack, p3_ack;
  logic        p0_rddata_valid, p1_rddata_valid, p2_rddata_valid, p3_rddata_valid;
  logic [31:0] rddata;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  modport slave (
    input  p0_addr, p1_addr, p2_addr, p3_addr,
    input  p0_wrdata, p1_wrdata, p2_wrdata, p3_wrdata,
    input  p0_wrbytesel, p1_wrbytesel, p2_wrbytesel, p3_wrbytesel,
    input  p0_write, p1_write, p2_write, p3_write,
    input  p0_strobe, p1_strobe, p2_strobe, p3_strobe,
    output p0_ack, p1_ack, p2_ack, p3_ack,
    output p0_rddata_valid, p1_rddata_valid, p2_rddata_valid, p3_rddata_valid,
    output rddata,
    output ram_addr, ram_wrdata, ram_wrbytesel, ram_write,
    input  ram_rddata
  );

  modport master (
    output p0_addr, p1_addr, p2_addr, p3_addr,
    output p0_wrdata, p1_wrdata, p2_wrdata, p3_wrdata,
    output p0_wrbytesel, p1_wrbytesel, p2_wrbytesel, p3_wrbytesel,
    output p0_write, p1_write, p2_write, p3_write,
    output p0_strobe, p1_strobe, p2_strobe, p3_strobe,
    input  p0_ack, p1_ack, p2_ack, p3_ack,
    input  p0_rddata_valid, p1_rddata_valid, p2_rddata_valid, p3_rddata_valid,
    input  rddata,
    input  ram_addr, ram_wrdata, ram_wrbytesel, ram_write,
    output ram_rddata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-ported 32-bit main RAM between four
// requesters. Port 0 (host) has fixed priority, capped at HOST_MAX_BURST
// consecutive grants while any renderer port (1-3) is waiting; ports 1-3
// are served round-robin. One grant per cycle, combinational ack.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vram_arbiter_if.slave (requester ports and RAM bus)
module vram_arbiter #(
  parameter int unsigned HOST_MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);

  localparam logic [3:0] HOST_MAX = 4'(HOST_MAX_BURST);

  logic [14:0] addr [4];
  logic [31:0] wdat [4];
  logic [3:0]  bsel [4];
  logic [3:0]  wr, stb, ack, rvalid;

  logic [1:0]  rr_ptr, rr_ptr_nxt;
  logic [3:0]  host_cnt, host_cnt_nxt;
  logic [1:0]  gnt_idx;
  logic        gnt_vld;
  logic        rr_req;
  logic [2:0]  cand;

  always_comb begin
    addr[0] = bus.p0_addr;      addr[1] = bus.p1_addr;
    addr[2] = bus.p2_addr;      addr[3] = bus.p3_addr;
    wdat[0] = bus.p0_wrdata;    wdat[1] = bus.p1_wrdata;
    wdat[2] = bus.p2_wrdata;    wdat[3] = bus.p3_wrdata;
    bsel[0] = bus.p0_wrbytesel; bsel[1] = bus.p1_wrbytesel;
    bsel[2] = bus.p2_wrbytesel; bsel[3] = bus.p3_wrbytesel;
    wr      = {bus.p3_write,  bus.p2_write,  bus.p1_write,  bus.p0_write};
    stb     = {bus.p3_strobe, bus.p2_strobe, bus.p1_strobe, bus.p0_strobe};
  end

  always_comb begin
    gnt_vld      = 1'b0;
    gnt_idx      = 2'd0;
    cand         = 3'd0;
    ack          = '0;
    rr_ptr_nxt   = rr_ptr;
    host_cnt_nxt = host_cnt;
    rr_req       = |stb[3:1];

    if (stb[0] && host_cnt < HOST_MAX) begin
      gnt_vld = 1'b1;
    end else if (rr_req) begin
      // Scan rr_ptr, rr_ptr+1, rr_ptr+2 with 3 wrapping back to 1.
      for (int unsigned i = 0; i < 3; i++) begin
        cand = {1'b0, rr_ptr} + 3'(i);
        if (cand > 3'd3) cand = cand - 3'd3;
        if (!gnt_vld && stb[cand[1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[1:0];
        end
      end
    end else if (stb[0]) begin
      gnt_vld = 1'b1;
    end

    if (gnt_vld) ack[gnt_idx] = 1'b1;

    if (gnt_vld && gnt_idx != 2'd0)
      rr_ptr_nxt = (gnt_idx == 2'd3) ? 2'd1 : gnt_idx + 2'd1;

    if (!rr_req || (gnt_vld && gnt_idx != 2'd0))
      host_cnt_nxt = '0;
    else if (gnt_vld && host_cnt < HOST_MAX)
      host_cnt_nxt = host_cnt + 4'd1;
  end

  always_comb begin
    bus.ram_addr      = '0;
    bus.ram_wrdata    = '0;
    bus.ram_wrbytesel = '0;
    bus.ram_write     = 1'b0;
    if (gnt_vld) begin
      bus.ram_addr      = addr[gnt_idx];
      bus.ram_wrdata    = wdat[gnt_idx];
      bus.ram_wrbytesel = bsel[gnt_idx];
      bus.ram_write     = wr[gnt_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= 2'd1;
      host_cnt <= '0;
      rvalid   <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      host_cnt <= host_cnt_nxt;
      rvalid   <= ack & ~wr;
    end
  end

  assign bus.p0_ack = ack[0];
  assign bus.p1_ack = ack[1];
  assign bus.p2_ack = ack[2];
  assign bus.p3_ack = ack[3];

  assign bus.p0_rddata_valid = rvalid[0];
  assign bus.p1_rddata_valid = rvalid[1];
  assign bus.p2_rddata_valid = rvalid[2];
  assign bus.p3_rddata_valid = rvalid[3];

  assign bus.rddata = bus.ram_rddata;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-ported 32-bit main RAM (15-bit word address, byte write enables, 1-cycle registered read) between four requesters.
- Port 0 is the host interface and has fixed priority.
- Ports 1-3 (layer 0, layer 1, sprite renderer) share the remaining slots round-robin.
- A starvation counter caps consecutive host grants so the renderers always make progress.

Parameters:
- HOST_MAX_BURST, 4, maximum consecutive port-0 grants while any of ports 1-3 is requesting; range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pN_addr  in  15  word address, N = 0..3
- pN_wrdata  in  32  write data, N = 0..3
- pN_wrbytesel  in  4  byte write enables, N = 0..3
- pN_write  in  1  1 = write, 0 = read, N = 0..3
- pN_strobe  in  1  request; held with address/data until ack, N = 0..3
- pN_ack  out  1  request accepted this cycle (combinational), N = 0..3
- pN_rddata_valid  out  1  rddata holds this port's read result (registered), N = 0..3
- rddata  out  32  read data shared by all ports; equals ram_rddata
- ram_addr  out  15  to RAM bus_addr
- ram_wrdata  out  32  to RAM bus_wrdata
- ram_wrbytesel  out  4  to RAM bus_wrbytesel
- ram_write  out  1  to RAM bus_write
- ram_rddata  in  32  from RAM bus_rddata

Behaviour:
- Arbitration is combinational each cycle; at most one grant per cycle; throughput is one access per cycle.
- Grant selection:
  - If p0_strobe=1 and host_cnt < HOST_MAX_BURST, grant port 0.
  - Otherwise grant the first requesting port among 1-3, searching from rr_ptr and wrapping 3->1.
  - If no port 1-3 is requesting, grant port 0 when p0_strobe=1 regardless of host_cnt.
- Signals in the grant cycle:
  - pN_ack=1 for the granted port only.
  - ram_addr, ram_wrdata and ram_wrbytesel come from the granted port.
  - ram_write = granted pN_write.
- No grant: ram_write=0, ram_wrbytesel=0, ram_addr=0, ram_wrdata=0, all acks 0.
- Read latency: a read acked in cycle T sets pN_rddata_valid=1 in cycle T+1 only. rddata (= ram_rddata) is valid in that cycle; the requester samples it then.
- Writes are acked the same way and complete in the ack cycle. A write never asserts rddata_valid.
- A write with wrbytesel=0 is still acked; the RAM contents are unchanged.
- rr_ptr (2 bits, values 1..3): when port k in 1..3 is granted, rr_ptr <= k+1, with 3 wrapping to 1. It is unchanged on a port-0 grant or no grant.
- host_cnt (4 bits):
  - Increments, saturating at HOST_MAX_BURST, on each port-0 grant while any of ports 1-3 is requesting.
  - Resets to 0 on any port 1-3 grant, or on any cycle with no port 1-3 request.
- Requester rules:
  - Deasserting strobe before ack is allowed and aborts the request.
  - Changing the address while strobe=1 and unacked is allowed; the value in the grant cycle is used.
  - Back-to-back strobes on one port are acked in consecutive cycles when uncontended.
- Reset (asynchronous, any time):
  - rr_ptr=1, host_cnt=0, all pN_rddata_valid=0.
  - Acks and ram_* follow the combinational rules, using the reset state.
  - An access acked in the cycle rst asserts produces no rddata_valid.
- Simultaneous requests from all four ports are resolved purely by the rules above; there are no other tie-breaks.

Test Plan:
- Single read: write p1 addr 0x0123 data 0xDEADBEEF bytesel 0xF, then read p1 addr 0x0123 -> p1_ack in cycle T, p1_rddata_valid in T+1 with rddata 0xDEADBEEF, other valids 0.
- Byte enables: p0 writes 0x11223344 (bytesel 0xF) to addr 0x4000, then 0xAABBCCDD with bytesel 0x5 -> read returns 0x11BB33DD from the upper bank (addr bit 14 = 1).
- Round-robin: ports 1-3 strobe continuously, p0 idle -> grant order 1,2,3,1,2,3; each port gets exactly 1 of every 3 cycles.
- Host cap: p0 and p2 strobe continuously, HOST_MAX_BURST=4 -> grants 0,0,0,0,2,0,0,0,0,2,...; with p2 idle, p0 is granted every cycle.
- Pipelined reads: p0 reads addrs 0,1,2 back-to-back -> acks in T..T+2, p0_rddata_valid in T+1..T+3 with data in address order.
- Reset mid-burst: assert rst the cycle after p3 is acked for a read -> p3_rddata_valid=0 immediately; after release, rr_ptr=1, so simultaneous p1/p3 requests grant p1 first.
